// File: rtl/sys_array_feeder_if.sv
// Handshake and output bundle for sys_array_feeder.
// Upstream side: in_valid/in_data/in_last in, in_ready out.
// Array side: out_data/out_valid skewed lanes, plus busy/done status.
interface sys_array_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4
);
  logic                          in_valid;
  logic                          in_ready;
  logic [ARRAY_W*DATA_WIDTH-1:0] in_data;
  logic                          in_last;
  logic [ARRAY_W*DATA_WIDTH-1:0] out_data;
  logic [ARRAY_W-1:0]            out_valid;
  logic                          busy;
  logic                          done;

  // Producer / consumer side driving the feeder.
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, out_data, out_valid, busy, done
  );

  // The feeder itself.
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/sys_array_feeder.sv
// Systolic array input feeder: accepts one ARRAY_W-lane vector per cycle and
// skews it so that lane i reaches array row i i cycles after lane 0.
// Ports:
//   clk    - single rising-edge clock
//   reset  - synchronous active-high reset
//   bus    - sys_array_feeder_if.slave (in_valid/in_ready/in_data/in_last,
//            out_data/out_valid, busy, done)
// ARRAY_W legal range is 2..16.
module sys_array_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4
) (
  input logic               clk,
  input logic               reset,
  sys_array_feeder_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(ARRAY_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Handshake and status decode purely from state.
  assign bus.in_ready = (state_q == IDLE) || (state_q == FEED);
  assign bus.busy     = (state_q == FEED) || (state_q == DRAIN);
  assign bus.done     = (state_q == DONE);
  assign accept       = bus.in_valid && bus.in_ready;

  // Batch sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(ARRAY_W - 1);
          end else begin
            state_d = FEED;
          end
        end
      end
      FEED: begin
        if (accept && bus.in_last) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(ARRAY_W - 1);
        end
      end
      DRAIN: begin
        // Counter holds ARRAY_W-1 on entry, so DRAIN spans exactly the
        // cycles needed for the last vector to leave lane ARRAY_W-1.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Per-lane delay line of depth i+1; non-accept cycles inject a zero bubble.
  for (genvar i = 0; i < ARRAY_W; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] dat_q [0:i];
    logic [DATA_WIDTH-1:0] dat_d [0:i];
    logic                  vld_q [0:i];
    logic                  vld_d [0:i];

    always_comb begin
      dat_d[0] = accept ? bus.in_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      vld_d[0] = accept;
      for (int j = 1; j <= i; j++) begin
        dat_d[j] = dat_q[j-1];
        vld_d[j] = vld_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= '0;
          vld_q[j] <= 1'b0;
        end
      end else begin
        for (int j = 0; j <= i; j++) begin
          dat_q[j] <= dat_d[j];
          vld_q[j] <= vld_d[j];
        end
      end
    end

    assign bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = dat_q[i];
    assign bus.out_valid[i]                         = vld_q[i];
  end

endmodule

// File: doc/sys_array_feeder.md
SYS_ARRAY_FEEDER -- requirements
Module: sys_array_feeder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of one signed input element.
REQ-002 SHALL have parameter ARRAY_W, default 4, number of array rows fed (lanes); legal range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream vector valid.
REQ-006 SHALL have port in_ready  output  1  feeder can accept a vector this cycle.
REQ-007 SHALL have port in_data  input  ARRAY_W*DATA_WIDTH  input vector; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH], signed.
REQ-008 SHALL have port in_last  input  1  marks final vector of a batch; sampled only on accept.
REQ-009 SHALL have port out_data  output  ARRAY_W*DATA_WIDTH  skewed vector; lane i drives input_data of array row i.
REQ-010 SHALL have port out_valid  output  ARRAY_W  per-lane valid of out_data.
REQ-011 SHALL have port busy  output  1  high in FEED or DRAIN.
REQ-012 SHALL have port done  output  1  one-cycle pulse when batch fully emitted.

Function
REQ-013 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-014 FSM states SHALL be IDLE, FEED, DRAIN, DONE.
REQ-015 IDLE: in_ready=1; accept without in_last -> FEED; accept with in_last -> DRAIN; no accept -> stay.
REQ-016 FEED: in_ready=1; accept with in_last -> DRAIN; otherwise stay (gaps allowed).
REQ-017 DRAIN: in_ready=0; drain counter loaded with ARRAY_W-1 on entry, decremented each cycle; counter reaching 0 -> DONE.
REQ-018 DONE: in_ready=0, done=1 for exactly one cycle -> IDLE.
REQ-019 Lane i SHALL be a registered delay line of depth i+1: element accepted at edge t appears on out_data lane i, with out_valid[i]=1, during cycle t+1+i.
REQ-020 Lane 0 latency SHALL be 1 cycle; lane ARRAY_W-1 latency ARRAY_W cycles.
REQ-021 Cycles without accept SHALL insert a bubble: data 0, valid 0, into every lane head, propagated with same skew.
REQ-022 Data SHALL pass unmodified; no arithmetic, no width change, sign preserved.
REQ-023 After last accept, lane ARRAY_W-1 last element SHALL be emitted in the final DRAIN cycle; done SHALL assert the cycle after.
REQ-024 DONE cycle and IDLE SHALL show out_valid all 0 and out_data all 0.
REQ-025 in_valid while in_ready=0 SHALL be ignored; upstream holds data.
REQ-026 in_last with in_valid=0 SHALL be ignored.
REQ-027 busy SHALL be combinational from state: 1 in FEED/DRAIN, else 0.
REQ-028 out_data/out_valid SHALL be register outputs; in_ready, busy and done SHALL depend only on state.

Reset
REQ-029 With reset=1 at an edge: state -> IDLE, all delay registers, out_data, out_valid -> 0, drain counter -> 0, done=0.
REQ-030 Reset SHALL take priority over any accept at the same edge; that vector is dropped.
REQ-031 Reset mid-FEED or mid-DRAIN SHALL discard in-flight data; no done pulse issued.
REQ-032 in_ready SHALL be 1 in the first cycle after reset release.

Verification (ARRAY_W=4, DATA_WIDTH=8)
REQ-033 Single vector {l3..l0}={4,3,2,1} with in_last in IDLE -> lane0=1 at t+1, lane1=2 at t+2, lane2=3 at t+3, lane3=4 at t+4, each with its valid bit only that cycle; done at t+5; in_ready low t+1..t+5.
REQ-034 Back-to-back vectors A={10,10,10,10}, B={-1,-1,-1,-1}, C={127,-128,5,0} (C last) -> at cycle t+3 lanes 0..2 show C0=0, B1=-1, A2=10, with lane3 invalid; done at t+7.
REQ-035 Gap: A accepted, one idle cycle, B last -> bubble (0, valid 0) appears diagonally between A and B on every lane.
REQ-036 in_valid held during DRAIN/DONE -> no accept; next vector accepted first IDLE cycle.
REQ-037 Reset asserted two cycles into DRAIN -> next cycle all outputs 0, in_ready=1, no done pulse.
REQ-038 Reset and accept at the same edge -> vector never appears on out_data.
